// File: rtl/pixel_fetch_ctrl_pkg.sv
// Shared types and helpers for the pixel fetch controller.
// Holds the controller state encoding, the default address width and the
// width helper used to size the in-flight credit count.
package pixel_fetch_pkg;

  localparam int PF_ADDR_W_DEFAULT = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } pf_state_t;

  // A count that must be able to hold the value n itself (0..n inclusive).
  function automatic int CNT_W(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pixel_fetch_ctrl_if.sv
// Memory read-request channel between the pixel fetch controller and memory.
// The controller is the master: it offers valid/address, memory answers ready.
interface pixel_fetch_ctrl_if
  import pixel_fetch_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W_DEFAULT
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);

endinterface

// File: rtl/pixel_fetch_ctrl_credit_counter.sv
// Up/down saturating count of read requests still inside the reorder window.
// A fire adds a credit, a sorted pixel returns one; returning a credit that
// was never taken leaves the count at zero and raises a sticky underflow flag.
module credit_counter
  import pixel_fetch_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_W(N)-1:0]  count,
  output logic [CNT_W(N)-1:0]  count_nxt,
  output logic                 underflow
);

  localparam int CW = CNT_W(N);

  logic uf_set;

  // Next count: clear wins, simultaneous inc/dec cancel, both ends saturate.
  always_comb begin
    count_nxt = count;
    uf_set    = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && !dec) begin
      if (count != CW'(N)) count_nxt = count + CW'(1);
    end else if (dec && !inc) begin
      if (count == '0) uf_set = 1'b1;
      else             count_nxt = count - CW'(1);
    end
  end

  // Count register and sticky underflow flag, cleared together with the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (clr)         underflow <= 1'b0;
      else if (uf_set) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Pixel fetch controller: walks a frame's pixel addresses in order, issuing
// one read per pixel while keeping at most N reads in flight so the reorder
// buffer index never aliases. Flushes the reorder buffer at frame start and
// reports frame completion once every credit has come back.
// Optional stall watchdog: define PIXEL_FETCH_TIMEOUT_EN to abort a frame
// after TIMEOUT_CYC cycles without any returned pixel.
module pixel_fetch_ctrl
  import pixel_fetch_pkg::*;
#(
  parameter int N            = 16,
  parameter int ADDR_W       = PF_ADDR_W_DEFAULT,
  parameter int FRAME_PIXELS = 307200,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [ADDR_W-1:0]    base_addr,
  pixel_fetch_ctrl_if.master   req,
  input  logic                 sorted_valid,
  output logic                 sort_flush,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W(N)-1:0]  outstanding,
  output logic                 err_underflow,
  output logic                 timeout
);

  localparam int CW    = CNT_W(N);
  localparam int ISS_W = $clog2(FRAME_PIXELS + 1);

  pf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ISS_W-1:0]  issued_q;
  logic              busy_q;
  logic              start_acc;
  logic              req_ok;
  logic              fire;
  logic              last_fire;
  logic              cnt_clr;
  logic              timeout_hit;
  logic [CW-1:0]     count_nxt;

  assign start_acc = (state_q == ST_IDLE) && frame_start;
  assign req_ok    = (state_q == ST_FETCH) &&
                     (issued_q < ISS_W'(FRAME_PIXELS)) &&
                     (outstanding < CW'(N));
  assign fire      = req_ok && req.req_ready;
  assign last_fire = fire && (issued_q == ISS_W'(FRAME_PIXELS - 1));
  assign cnt_clr   = start_acc || timeout_hit;

  assign req.req_valid = req_ok;
  assign req.req_addr  = base_q + ADDR_W'(issued_q);
  assign busy          = busy_q;
  assign frame_done    = (state_q == ST_DONE);
  assign timeout       = timeout_hit;

`ifdef PIXEL_FETCH_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT_CYC + 1);

  logic [ST_W-1:0] stall_q;
  logic            stall_cond;

  assign stall_cond  = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) &&
                       (outstanding != '0) && !sorted_valid;
  assign timeout_hit = stall_cond && (stall_q == ST_W'(TIMEOUT_CYC - 1));

  // Cycles since the last returned pixel while reads are still owed.
  always_ff @(posedge clk) begin
    if (rst || start_acc || timeout_hit || sorted_valid) stall_q <= '0;
    else if (stall_cond)                                 stall_q <= stall_q + ST_W'(1);
  end
`else
  // Watchdog absent: the stall limit has no effect and the FSM waits forever.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  credit_counter #(.N(N)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (fire),
    .dec       (sorted_valid),
    .count     (outstanding),
    .count_nxt (count_nxt),
    .underflow (err_underflow)
  );

  // Frame sequencing: next state and the reorder-buffer flush pulse.
  always_comb begin
    state_d    = state_q;
    sort_flush = 1'b0;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_FLUSH;
      ST_FLUSH: begin
        sort_flush = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FETCH: if (last_fire) state_d = ST_DRAIN;
      ST_DRAIN: if (count_nxt == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (timeout_hit) begin
      sort_flush = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  // State, latched frame base, issue counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      if (start_acc) begin
        base_q   <= base_addr;
        issued_q <= '0;
      end else if (timeout_hit) begin
        issued_q <= '0;
      end else if (fire) begin
        issued_q <= issued_q + ISS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Self-checking bench for pixel_fetch_ctrl (N=16, 64-pixel frames).
// A frame-level reference model tracks issued pixels, credits in flight and
// the flush/done timeline; every cycle the DUT outputs are compared against it.
module tb_pixel_fetch_ctrl;
  import pixel_fetch_pkg::*;

  localparam int N      = 16;
  localparam int ADDR_W = 20;
  localparam int FP     = 64;
  localparam int TO     = 32;

  logic                clk;
  logic                rst;
  logic                frame_start;
  logic [ADDR_W-1:0]   base_addr;
  logic                sorted_valid;
  logic                sort_flush;
  logic                busy;
  logic                frame_done;
  logic [CNT_W(N)-1:0] outstanding;
  logic                err_underflow;
  logic                timeout;

  pixel_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  pixel_fetch_ctrl #(
    .N            (N),
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FP),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .base_addr     (base_addr),
    .req           (bus),
    .sorted_valid  (sorted_valid),
    .sort_flush    (sort_flush),
    .busy          (busy),
    .frame_done    (frame_done),
    .outstanding   (outstanding),
    .err_underflow (err_underflow),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int due_q[$];
  int dly_min = 3;
  int dly_max = 3;

  // Reference model: frame timeline measured in cycles since accepted start.
  bit          m_active;
  bit          m_done_now;
  bit          m_err;
  int          m_age;
  int          m_issued;
  int          m_out;
  logic [19:0] m_base;

  logic [30:0] obs_v, exp_v;
  bit          t_fire;
  logic [19:0] t_addr;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d (need finish before limit)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_clear();
    m_active = 0; m_done_now = 0; m_err = 0;
    m_age = 0; m_issued = 0; m_out = 0; m_base = '0;
    due_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; frame_start = 1'b0; sorted_valid = 1'b0;
    bus.req_ready = 1'b0; base_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs at negedge, capture observed and expected outputs,
  // then advance the reference model with this cycle's inputs.
  task automatic tick(input bit fs, input bit rdy, input bit sv_in, input bit auto_cr);
    bit          sv, e_rv, e_fl, was_drain;
    logic [19:0] e_addr;
    @(negedge clk);
    sv = sv_in;
    if (auto_cr) begin
      for (int i = 0; i < due_q.size(); i++) begin
        if (due_q[i] <= cyc) begin
          due_q.delete(i);
          sv = 1'b1;
          break;
        end
      end
    end
    frame_start = fs; bus.req_ready = rdy; sorted_valid = sv;
    #1;
    e_rv   = m_active && (m_age >= 2) && (m_issued < FP) && (m_out < N);
    e_fl   = m_active && (m_age == 1);
    e_addr = m_base + 20'(m_issued);
    exp_v  = {e_rv, (e_rv ? e_addr : 20'h0), e_fl, m_active, m_done_now,
              5'(m_out), m_err, 1'b0};
    obs_v  = {bus.req_valid, (bus.req_valid ? bus.req_addr : 20'h0), sort_flush,
              busy, frame_done, outstanding, err_underflow, timeout};
    t_fire = e_rv && rdy;
    t_addr = bus.req_addr;
    if (t_fire && auto_cr) due_q.push_back(cyc + int'($urandom_range(dly_max, dly_min)));
    if (!m_active && fs) begin
      m_active = 1; m_age = 1; m_issued = 0; m_out = 0; m_err = 0;
      m_base = base_addr; m_done_now = 0;
    end else begin
      was_drain = m_active && (m_issued == FP) && !m_done_now;
      if (t_fire && !sv) m_out++;
      else if (sv && !t_fire) begin
        if (m_out == 0) m_err = 1;
        else            m_out--;
      end
      if (t_fire) m_issued++;
      if (m_done_now) begin
        m_active = 0; m_done_now = 0;
      end else if (was_drain && m_out == 0) begin
        m_done_now = 1;
      end
      if (m_active) m_age++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.req_valid, sort_flush, busy, frame_done, outstanding, err_underflow, timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_flags got=%b exp=0",
               {bus.req_valid, sort_flush, busy, frame_done, outstanding, err_underflow, timeout});
    end
    checks++;
    if (bus.req_addr !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_addr got=%h exp=00000", bus.req_addr);
    end
  endtask

  task automatic test_stream();
    int nfired = 0, ndone = 0, peak = 0;
    logic [19:0] b;
    b = 20'($urandom) & 20'hFFFF0;
    dly_min = 3; dly_max = 3;
    base_addr = b;
    tick(1, 1, 0, 1);
    for (int k = 0; k < 100; k++) begin
      tick(0, 1, 0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (t_fire) begin
        checks++;
        if (t_addr !== b + 20'(nfired)) begin
          errors++;
          $display("[TB] FAIL stream_addr n=%0d got=%h exp=%h", nfired, t_addr, b + 20'(nfired));
        end
        nfired++;
      end
      if (frame_done === 1'b1) ndone++;
      if (int'(outstanding) > peak) peak = int'(outstanding);
    end
    checks++;
    if (nfired != FP) begin errors++; $display("[TB] FAIL stream_count got=%0d exp=%0d", nfired, FP); end
    checks++;
    if (ndone != 1) begin errors++; $display("[TB] FAIL stream_done got=%0d exp=1", ndone); end
    checks++;
    if (peak != 3) begin errors++; $display("[TB] FAIL stream_peak got=%0d exp=3", peak); end
  endtask

  task automatic test_random_stream();
    int nfired = 0, ndone = 0;
    logic [19:0] b;
    b = 20'hFFFE0;
    dly_min = 1; dly_max = 8;
    base_addr = b;
    tick(1, 1, 0, 1);
    for (int k = 0; k < 400; k++) begin
      if (k == 15) base_addr = 20'h12340;
      tick((k == 15), ($urandom_range(3, 0) != 0), 0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (t_fire) begin
        checks++;
        if (t_addr !== b + 20'(nfired)) begin
          errors++;
          $display("[TB] FAIL random_addr n=%0d got=%h exp=%h", nfired, t_addr, b + 20'(nfired));
        end
        nfired++;
      end
      if (frame_done === 1'b1) ndone++;
    end
    checks++;
    if (nfired != FP) begin errors++; $display("[TB] FAIL random_count got=%0d exp=%0d", nfired, FP); end
    checks++;
    if (ndone != 1) begin errors++; $display("[TB] FAIL random_done got=%0d exp=1", ndone); end
  endtask

  task automatic test_credit_limit();
    int nfired = 0, extra = 0;
    base_addr = 20'($urandom) & 20'hFFFF0;
    tick(1, 1, 0, 0);
    for (int k = 0; k < 25; k++) begin
      tick(0, 1, 0, 0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL limit cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (t_fire) nfired++;
    end
    checks++;
    if (nfired != N) begin errors++; $display("[TB] FAIL limit_count got=%0d exp=%0d", nfired, N); end
    checks++;
    if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL limit_valid got=%b exp=0", bus.req_valid); end
    tick(0, 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 0, 0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL one_more cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (t_fire) extra++;
    end
    checks++;
    if (extra != 1) begin errors++; $display("[TB] FAIL one_more_count got=%0d exp=1", extra); end
    // Credit return and a new fire in the same cycle near the window limit.
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL same_cycle got=%h exp=%h", obs_v, exp_v); end
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (outstanding !== 5'd16 || bus.req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL window_full out=%0d valid=%b exp out=16 valid=0", outstanding, bus.req_valid);
    end
    // Stream the rest of the frame with a credit back every cycle, then reset mid-drain.
    for (int k = 0; k < 100 && m_issued < FP; k++) begin
      tick(0, 1, 1, 0);
      checks++;
      if (obs_v !== exp_v || outstanding > 5'd16) begin
        errors++;
        $display("[TB] FAIL stream_full cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
    end
    repeat (3) tick(0, 1, 1, 0);
    checks++;
    if (obs_v !== exp_v || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    end
    @(negedge clk);
    rst = 1'b1; sorted_valid = 1'b0; bus.req_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.req_valid, bus.req_addr, sort_flush, busy, frame_done, outstanding, err_underflow, timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_drain got=%h exp=0",
               {bus.req_valid, bus.req_addr, sort_flush, busy, frame_done, outstanding, err_underflow, timeout});
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_underflow_idle();
    tick(0, 0, 1, 0);
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL uf_pulse got=%h exp=%h", obs_v, exp_v); end
    tick(0, 0, 0, 0);
    checks++;
    if (err_underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_set got=%b exp=1", err_underflow); end
    base_addr = 20'($urandom) & 20'hFFFF0;
    tick(1, 0, 0, 0);
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL uf_start got=%h exp=%h", obs_v, exp_v); end
    tick(0, 0, 0, 0);
    checks++;
    if (err_underflow !== 1'b0 || sort_flush !== 1'b1) begin
      errors++;
      $display("[TB] FAIL uf_clear err=%b flush=%b exp err=0 flush=1", err_underflow, sort_flush);
    end
  endtask

  task automatic test_timeout();
    int hit_at = 0;
    bit saw_done = 0;
    base_addr = 20'($urandom) & 20'hFFFF0;
    tick(1, 1, 0, 0);
    repeat (20) tick(0, 1, 0, 0);
`ifdef PIXEL_FETCH_TIMEOUT_EN
    tick(0, 1, 1, 0);
    for (int k = 1; k <= 60; k++) begin
      tick(0, 1, 0, 0);
      if (frame_done === 1'b1) saw_done = 1;
      if (timeout === 1'b1) begin
        hit_at = k;
        checks++;
        if (sort_flush !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flush got=%b exp=1", sort_flush); end
        break;
      end
    end
    checks++;
    if (hit_at != TO) begin errors++; $display("[TB] FAIL timeout_cycle got=%0d exp=%0d", hit_at, TO); end
    tick(0, 1, 0, 0);
    checks++;
    if (busy !== 1'b0 || saw_done) begin
      errors++;
      $display("[TB] FAIL timeout_idle busy=%b done_seen=%b exp busy=0 done_seen=0", busy, saw_done);
    end
`else
    for (int k = 0; k < 40; k++) begin
      tick(0, 1, 0, 0);
      if (timeout === 1'b1) hit_at++;
      if (frame_done === 1'b1) saw_done = 1;
    end
    checks++;
    if (hit_at != 0 || saw_done || busy !== 1'b1 || outstanding !== 5'd16) begin
      errors++;
      $display("[TB] FAIL no_timeout pulses=%0d done_seen=%b busy=%b out=%0d exp 0/0/1/16",
               hit_at, saw_done, busy, outstanding);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; sorted_valid = 1'b0;
    base_addr = '0; bus.req_ready = 1'b0;
    model_clear();
    test_reset();
    test_stream();
    test_random_stream();
    test_credit_limit();
    do_reset();
    test_underflow_idle();
    do_reset();
    test_timeout();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
